// File: rtl/o_serdes_mc.sv
// o_serdes_mc: multi-lane output serializer (SDR or DDR) fed from a shared word FIFO,
// with PLL lock gating, idle fill on underrun and word-boundary/status outputs.
module o_serdes_mc #(
    parameter int               WIDTH        = 4,
    parameter int               NUM_CH       = 2,
    parameter int               DEPTH        = 4,
    parameter string            DATA_RATE    = "SDR",
    parameter bit               MSB_FIRST    = 1'b1,
    parameter int               LOCK_DLY     = 32,
    parameter logic [WIDTH-1:0] IDLE_PATTERN = '0,
    localparam int              BPC          = (DATA_RATE == "DDR") ? 2 : 1,
    localparam int              LW           = $clog2(DEPTH + 1)
) (
    input  logic                    PLL_CLK,
    input  logic                    RST,
    input  logic [NUM_CH*WIDTH-1:0] D,
    input  logic [NUM_CH-1:0]       OE_IN,
    input  logic                    DATA_VALID,
    output logic                    DATA_READY,
    input  logic                    PLL_LOCK,
    output logic [NUM_CH*BPC-1:0]   Q,
    output logic [NUM_CH-1:0]       OE_OUT,
    output logic                    WORD_START,
    output logic                    UNDERRUN,
    output logic [LW-1:0]           LEVEL
);

    localparam int SLOTS = WIDTH / BPC;
    localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(LOCK_DLY + 1);
    localparam int FW    = NUM_CH*WIDTH + NUM_CH;

    if (WIDTH < 3 || WIDTH > 10) begin : g_bad_width
        $fatal(1, "o_serdes_mc: WIDTH must be 3..10");
    end
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $fatal(1, "o_serdes_mc: NUM_CH must be 1..8");
    end
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "o_serdes_mc: DEPTH must be a power of 2 in 2..16");
    end
    if (DATA_RATE != "SDR" && DATA_RATE != "DDR") begin : g_bad_rate
        $fatal(1, "o_serdes_mc: DATA_RATE must be SDR or DDR");
    end
    if (DATA_RATE == "DDR" && (WIDTH % 2) != 0) begin : g_bad_ddr_width
        $fatal(1, "o_serdes_mc: DDR requires an even WIDTH");
    end
    if (LOCK_DLY < 1 || LOCK_DLY > 255) begin : g_bad_lock_dly
        $fatal(1, "o_serdes_mc: LOCK_DLY must be 1..255");
    end

    typedef logic [WIDTH-1:0] lane_t;

    logic [FW-1:0]     mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     count_q, count_d;
    logic [CW-1:0]     lock_cnt_q, lock_cnt_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic              run_q, run_d;
    logic              ws_q, ws_d;
    logic              started_q, started_d;
    logic              underrun_q, underrun_d;
    logic [NUM_CH-1:0] oe_q, oe_d;
    lane_t             sr_q [NUM_CH];
    lane_t             sr_d [NUM_CH];
    logic              active, load_pt, push, pop;
    logic [FW-1:0]     head;

    // The shift register always emits from its top bits; LSB-first words are mirrored at load.
    function automatic lane_t order_bits(input lane_t w);
        lane_t r;
        r = w;
        if (!MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) r[i] = w[WIDTH-1-i];
        end
        return r;
    endfunction

    assign DATA_READY = (count_q < LW'(DEPTH)) & ~RST;
    assign push       = DATA_VALID & DATA_READY;
    assign head       = mem_q[rd_ptr_q];
    assign active     = (lock_cnt_q == CW'(LOCK_DLY));
    assign load_pt    = active & (~run_q | (slot_q == SW'(SLOTS - 1)));

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        run_d      = run_q;
        slot_d     = slot_q;
        ws_d       = ws_q;
        oe_d       = oe_q;
        sr_d       = sr_q;
        started_d  = started_q;
        underrun_d = underrun_q;
        pop        = 1'b0;
        if (!PLL_LOCK) begin
            lock_cnt_d = '0;
            run_d      = 1'b0;
            slot_d     = '0;
            ws_d       = 1'b0;
            oe_d       = '0;
            for (int c = 0; c < NUM_CH; c++) sr_d[c] = '0;
        end else if (!active) begin
            lock_cnt_d = lock_cnt_q + CW'(1);
        end else if (load_pt) begin
            run_d  = 1'b1;
            slot_d = '0;
            ws_d   = 1'b1;
            if (count_q != '0) begin
                pop       = 1'b1;
                started_d = 1'b1;
                oe_d      = head[NUM_CH*WIDTH +: NUM_CH];
                for (int c = 0; c < NUM_CH; c++) sr_d[c] = order_bits(head[c*WIDTH +: WIDTH]);
            end else begin
                oe_d = '0;
                for (int c = 0; c < NUM_CH; c++) sr_d[c] = order_bits(IDLE_PATTERN);
                if (started_q) underrun_d = 1'b1;
            end
        end else begin
            slot_d = slot_q + SW'(1);
            ws_d   = 1'b0;
            for (int c = 0; c < NUM_CH; c++) sr_d[c] = sr_q[c] << BPC;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + LW'(push) - LW'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge PLL_CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lock_cnt_q <= '0;
            slot_q     <= '0;
            run_q      <= 1'b0;
            ws_q       <= 1'b0;
            started_q  <= 1'b0;
            underrun_q <= 1'b0;
            oe_q       <= '0;
            for (int c = 0; c < NUM_CH; c++) sr_q[c] <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lock_cnt_q <= lock_cnt_d;
            slot_q     <= slot_d;
            run_q      <= run_d;
            ws_q       <= ws_d;
            started_q  <= started_d;
            underrun_q <= underrun_d;
            oe_q       <= oe_d;
            sr_q       <= sr_d;
        end
    end

    // NOTE: the storage array is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge PLL_CLK) begin
        if (push) mem_q[wr_ptr_q] <= {OE_IN, D};
    end

    always_comb begin
        Q = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int b = 0; b < BPC; b++) Q[c*BPC + b] = sr_q[c][WIDTH-1-b];
        end
    end

    assign OE_OUT     = oe_q;
    assign WORD_START = ws_q;
    assign UNDERRUN   = underrun_q;
    assign LEVEL      = count_q;

endmodule

// File: tb/tb_o_serdes_mc.sv
// Bench for o_serdes_mc: randomized SDR traffic against a queue-based reference model,
// plus a directed LSB-first DDR instance.
module tb_o_serdes_mc;

    localparam int              W        = 4;
    localparam int              NCH      = 2;
    localparam int              DEPTH    = 4;
    localparam int              LOCK_DLY = 5;
    localparam int              BPC      = 1;
    localparam int              SLOTS    = W / BPC;
    localparam bit              MSBF     = 1'b1;
    localparam logic [W-1:0]    IDLE     = 4'h0;

    logic               pll_clk = 1'b0;
    logic               rst;
    logic [NCH*W-1:0]   d;
    logic [NCH-1:0]     oe_in;
    logic               data_valid, data_ready, pll_lock;
    logic [NCH*BPC-1:0] q;
    logic [NCH-1:0]     oe_out;
    logic               word_start, underrun;
    logic [2:0]         level;

    logic [3:0] dd_d;
    logic       dd_oe, dd_valid, dd_ready, dd_lock;
    logic [1:0] dd_q;
    logic       dd_oe_out, dd_ws, dd_ur;
    logic [1:0] dd_level;

    o_serdes_mc #(
        .WIDTH(W), .NUM_CH(NCH), .DEPTH(DEPTH), .DATA_RATE("SDR"), .MSB_FIRST(MSBF),
        .LOCK_DLY(LOCK_DLY), .IDLE_PATTERN(IDLE)
    ) u_dut (
        .PLL_CLK(pll_clk), .RST(rst), .D(d), .OE_IN(oe_in), .DATA_VALID(data_valid),
        .DATA_READY(data_ready), .PLL_LOCK(pll_lock), .Q(q), .OE_OUT(oe_out),
        .WORD_START(word_start), .UNDERRUN(underrun), .LEVEL(level)
    );

    o_serdes_mc #(
        .WIDTH(4), .NUM_CH(1), .DEPTH(2), .DATA_RATE("DDR"), .MSB_FIRST(1'b0),
        .LOCK_DLY(2), .IDLE_PATTERN(4'b0110)
    ) u_ddr (
        .PLL_CLK(pll_clk), .RST(rst), .D(dd_d), .OE_IN(dd_oe), .DATA_VALID(dd_valid),
        .DATA_READY(dd_ready), .PLL_LOCK(dd_lock), .Q(dd_q), .OE_OUT(dd_oe_out),
        .WORD_START(dd_ws), .UNDERRUN(dd_ur), .LEVEL(dd_level)
    );

    always #5 pll_clk = ~pll_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue of words, output as a queue of per-cycle samples.
    typedef struct packed {
        logic [NCH-1:0]   oe;
        logic [NCH*W-1:0] d;
    } word_t;
    typedef struct packed {
        logic [NCH*BPC-1:0] q;
        logic [NCH-1:0]     oe;
        logic               ws;
    } smp_t;

    word_t mq[$];
    smp_t  pend[$];
    smp_t  cur = '0;
    int    lock_cnt = 0;
    bit    started = 1'b0;
    bit    ur = 1'b0;
    bit    accepted = 1'b0;

    task automatic model_reset();
        mq.delete();
        pend.delete();
        cur      = '0;
        lock_cnt = 0;
        started  = 1'b0;
        ur       = 1'b0;
    endtask

    task automatic model_edge();
        word_t w;
        smp_t  s;
        int    k;
        if (!pll_lock) begin
            lock_cnt = 0;
            pend.delete();
            cur = '0;
        end else if (lock_cnt < LOCK_DLY) begin
            lock_cnt++;
        end else begin
            if (pend.size() == 0) begin
                if (mq.size() > 0) begin
                    w = mq.pop_front();
                    started = 1'b1;
                end else begin
                    w.oe = '0;
                    for (int c = 0; c < NCH; c++) w.d[c*W +: W] = IDLE;
                    if (started) ur = 1'b1;
                end
                for (int sl = 0; sl < SLOTS; sl++) begin
                    s.ws = (sl == 0);
                    s.oe = w.oe;
                    s.q  = '0;
                    for (int c = 0; c < NCH; c++) begin
                        for (int b = 0; b < BPC; b++) begin
                            k = sl*BPC + b;
                            s.q[c*BPC + b] = MSBF ? w.d[c*W + W-1-k] : w.d[c*W + k];
                        end
                    end
                    pend.push_back(s);
                end
            end
            cur = pend.pop_front();
        end
    endtask

    task automatic step();
        bit    push;
        word_t wn;
        push  = data_valid && (mq.size() < DEPTH);
        wn.oe = oe_in;
        wn.d  = d;
        model_edge();
        if (push) mq.push_back(wn);
        @(posedge pll_clk);
        #1;
        accepted = push;
        check("q", q, cur.q);
        check("oe_out", oe_out, cur.oe);
        check("word_start", word_start, cur.ws);
        check("underrun", underrun, ur);
        check("level", level, mq.size());
        check("data_ready", data_ready, (mq.size() < DEPTH));
    endtask

    task automatic new_word();
        d     = (NCH*W)'($urandom);
        oe_in = NCH'($urandom);
    endtask

    task automatic fill(input int target);
        int guard;
        pll_lock   = 1'b0;
        data_valid = 1'b1;
        new_word();
        guard = 0;
        while (mq.size() < target && guard < 20) begin
            step();
            if (accepted) new_word();
            guard++;
        end
        data_valid = 1'b0;
        check("fill_level", mq.size(), target);
    endtask

    task automatic wait_ws(input string tag, input int max_steps, output int n);
        bit found;
        found = 1'b0;
        n = 0;
        while (!found && n < max_steps) begin
            step();
            n++;
            found = cur.ws;
        end
        check(tag, found, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_q"}, q, 0);
        check({tag, "_oe"}, oe_out, 0);
        check({tag, "_ws"}, word_start, 0);
        check({tag, "_ur"}, underrun, 0);
        check({tag, "_level"}, level, 0);
        check({tag, "_ready"}, data_ready, 0);
        check({tag, "_ddr_q"}, dd_q, 0);
        check({tag, "_ddr_ready"}, dd_ready, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int off_cnt;
        int rate;

        rst = 1'b1;
        pll_lock = 1'b0; data_valid = 1'b0; d = '0; oe_in = '0;
        dd_d = '0; dd_oe = 1'b0; dd_valid = 1'b0; dd_lock = 1'b0;
        repeat (2) @(posedge pll_clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        #1;
        check("ready_after_reset", data_ready, 1'b1);
        check("ddr_ready_after_reset", dd_ready, 1'b1);

        // DDR, LSB first: word 1101 then idle 0110.
        dd_d = 4'b1101; dd_oe = 1'b1; dd_valid = 1'b1;
        step();
        dd_valid = 1'b0;
        check("ddr_level", dd_level, 1);
        dd_lock = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("ddr_lock_wait_ws", dd_ws, 1'b0);
        end
        step();
        check("ddr_s0_q", dd_q, 2'b01);
        check("ddr_s0_ws", dd_ws, 1'b1);
        check("ddr_s0_oe", dd_oe_out, 1'b1);
        check("ddr_s0_ur", dd_ur, 1'b0);
        check("ddr_s0_level", dd_level, 0);
        step();
        check("ddr_s1_q", dd_q, 2'b11);
        check("ddr_s1_ws", dd_ws, 1'b0);
        check("ddr_s1_oe", dd_oe_out, 1'b1);
        step();
        check("ddr_idle0_q", dd_q, 2'b10);
        check("ddr_idle0_ws", dd_ws, 1'b1);
        check("ddr_idle0_oe", dd_oe_out, 1'b0);
        check("ddr_idle0_ur", dd_ur, 1'b1);
        step();
        check("ddr_idle1_q", dd_q, 2'b01);
        check("ddr_idle1_ws", dd_ws, 1'b0);
        step();
        check("ddr_period_ws", dd_ws, 1'b1);
        dd_lock = 1'b0;
        step();
        check("ddr_lockloss_q", dd_q, 2'b00);
        check("ddr_lockloss_ur", dd_ur, 1'b1);

        // Idle loads before any traffic must not flag underrun.
        pll_lock = 1'b1;
        repeat (LOCK_DLY + 12) step();
        check("ur_pre_traffic", underrun, 1'b0);
        pll_lock = 1'b0;
        step();

        // Five writes into a DEPTH=4 FIFO while unlocked; fifth waits for the first pop.
        d = {4'h5, 4'hA}; oe_in = 2'b11; data_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (accepted) new_word();
        end
        check("full_level", level, 4);
        check("full_ready", data_ready, 1'b0);
        pll_lock = 1'b1;
        n = 0;
        accepted = 1'b0;
        while (!accepted && n < 40) begin
            step();
            n++;
        end
        check("fifth_word_accepted", accepted, 1'b1);
        data_valid = 1'b0;
        repeat (30) step();
        check("ur_sticky", underrun, 1'b1);

        // Randomized traffic with occasional lock loss.
        off_cnt = 0;
        data_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rate = (i < 1000) ? 20 : ((i < 2000) ? 30 : 60);
            if (off_cnt > 0) off_cnt--;
            else if ($urandom_range(0, 199) == 0) off_cnt = $urandom_range(1, 12);
            pll_lock = (off_cnt == 0);
            if (!data_valid || accepted) begin
                data_valid = ($urandom_range(0, 99) < rate);
                if (data_valid) new_word();
            end
            step();
        end

        // Drain, then lock loss at slot 2 of a word with two words still queued.
        data_valid = 1'b0;
        pll_lock = 1'b1;
        n = 0;
        while (mq.size() > 0 && n < 200) begin
            step();
            n++;
        end
        check("drained", mq.size(), 0);
        fill(3);
        pll_lock = 1'b1;
        wait_ws("lockloss_first_ws", 3*LOCK_DLY, n);
        step();
        step();
        pll_lock = 1'b0;
        step();
        check("lockloss_q", q, 0);
        check("lockloss_oe", oe_out, 0);
        check("lockloss_level", level, 2);
        pll_lock = 1'b1;
        wait_ws("relock_ws", 3*LOCK_DLY, n);
        check("relock_delay", n, LOCK_DLY + 1);
        check("relock_level", level, 1);

        // Asynchronous reset in the middle of a word with three words queued.
        fill(4);
        pll_lock = 1'b1;
        wait_ws("pre_reset_ws", 3*LOCK_DLY, n);
        step();
        check("pre_reset_level", level, 3);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        model_reset();
        pll_lock = 1'b0;
        data_valid = 1'b0;
        @(posedge pll_clk);
        #1;
        check_all_zero("reset_hold");
        rst = 1'b0;
        #1;
        check("ready_after_rst2", data_ready, 1'b1);
        check("ur_after_rst2", underrun, 1'b0);

        pll_lock = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (!data_valid || accepted) begin
                data_valid = ($urandom_range(0, 99) < 25);
                if (data_valid) new_word();
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
